regbank_mp: RTL
===============

# regbank_mp

Parametrised multi-port integer register bank: the next-generation register file for the CPU datapath. It provides configurable width and depth, NUM_RD combinational read ports and two prioritised write ports. The top address is a hardwired zero register (XZR). After reset, or on request, a hardware clear sequencer zeroes the array one entry per cycle. The block sits between the decode stage, which drives the read addresses, and the writeback stage, which drives the write ports.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports, 1..4
- ZERO_IDX, 2**ADDR_W-1, index of the hardwired zero register

Ports:
- Clk  input  1  single clock; all state updates on the rising edge
- Rst_n  input  1  asynchronous, active-low reset
- RdAddr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- RdData  output  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- WrEn  input  2  write enables; bit k enables write port k
- WrAddr  input  2*ADDR_W  write addresses, packed by port
- WrData  input  2*DATA_W  write data, packed by port
- Clear  input  1  synchronous request to re-run the clear sequence
- Ready  output  1  high when the bank accepts writes and returns array data

## Operation
- The FSM has two states: CLEAR and RUN.
- Reset forces CLEAR with clear counter = 0 and Ready = 0. The array contents are not reset.
- CLEAR behaviour:
  - Each cycle, entry[counter] is written with 0 and the counter increments.
  - When the counter reaches DEPTH-1, that entry is written and the next state is RUN.
  - WrEn is ignored.
  - Clear is ignored; it does not restart the counter.
  - All RdData ports return 0.
- RUN behaviour:
  - Ready = 1.
  - Clear = 1 moves the FSM to CLEAR on the next edge with counter = 0. Writes in that same cycle are still performed.
- Writes in RUN, at the rising edge:
  - The write to WrAddr[k] takes effect if WrEn[k] = 1 and WrAddr[k] != ZERO_IDX.
  - A write to ZERO_IDX is silently discarded.
  - If both ports write the same address, port 1 wins.
- Reads are combinational:
  - RdData[i] = entry[RdAddr[i]].
  - RdAddr[i] == ZERO_IDX always returns 0, whatever the array holds.
- The counter is ADDR_W bits wide. Its terminal value is DEPTH-1, so it never wraps.

## Timing
- Read latency is 0 cycles, purely combinational from RdAddr.
- Write-to-read visibility is the next cycle. It is the same cycle when bypass is compiled in; see Configuration.
- The clear sequence takes exactly DEPTH cycles. Ready rises on the first edge after the write of entry DEPTH-1.
- From Rst_n deassertion to Ready = 1 is DEPTH rising edges. With defaults this is 32 cycles.
- Reset values:
  - Ready = 0.
  - RdData = 0 on all ports, because the FSM is in CLEAR.
- Asserting Rst_n mid-clear or mid-run returns the FSM to CLEAR with counter 0, asynchronously.

## Configuration
- The macro REGBANK_BYPASS_EN controls same-cycle write-to-read forwarding.
- Defined:
  - In RUN, if WrEn[k] = 1 and WrAddr[k] == RdAddr[i] != ZERO_IDX, then RdData[i] = WrData[k] in the same cycle.
  - When both ports match, port 1's data is forwarded.
  - There is no forwarding in CLEAR.
- Undefined:
  - RdData reflects array contents only.
  - A written value becomes visible the cycle after the write edge.

## Structure
- Shared package regbank_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - default parameter constants (DATA_W_DEF = 64, ADDR_W_DEF = 5);
  - a function returning the write-port priority winner.
- Sub-module regbank_clear_fsm holds the state register, the clear counter, the Ready output, and the clear write enable/address.
- The top level holds the array, the write muxing and the read/bypass logic.

## Test plan
- Reset release, then hold WrEn = 0: Ready stays 0 for 32 cycles and all RdData = 0; Ready = 1 on cycle 32, and reading addresses 0..30 returns 0.
- RUN, port 0 writes r3 = 0x1234, then read r3 on the next cycle: RdData = 0x1234. With REGBANK_BYPASS_EN, RdData = 0x1234 in the write cycle itself; without it, the old value is returned in that cycle.
- Both ports write r7 in the same cycle, port 0 = 0xAAAA and port 1 = 0x5555: r7 reads 0x5555 afterwards.
- Write r31 = 0xFFFF, then read r31 on all NUM_RD ports: 0 every cycle, including in the write cycle with bypass compiled in.
- Load r0..r30 with nonzero values, pulse Clear in RUN while also writing r5 = 0x77: Ready drops on the next edge, reads return 0 for 32 cycles, and afterwards r5 = 0 and every register = 0.
- Pull Rst_n low at clear counter 10, release two cycles later: Ready = 0 for a fresh 32 cycles, and a WrEn write during that window does not take effect.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared definitions for the multi-port register bank: state encoding,
// default geometry and the write-port priority rule.
package regbank_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Given which write ports hit a location, return the index of the port
  // whose data lands there. Port 1 has priority over port 0.
  function automatic logic wr_prio_sel(input logic [1:0] hit);
    return hit[1];
  endfunction

endpackage

// File: rtl/regbank_clear_fsm.sv
// Clear sequencer for the register bank. After reset, or on a clear request
// while running, it walks a counter over every entry (one per cycle) and
// asks the array to zero that entry; Ready is high only once the walk is done.
module regbank_clear_fsm
  import regbank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  // Last entry of the walk; the counter stops here and never wraps.
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'((2 ** ADDR_W) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset restarts the clear walk from entry 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: walk the array in CLEAR, wait for a clear request in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_o  = 1'b0;
    clr_we_o = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Clear requests are ignored here; the walk always completes.
        clr_we_o = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        ready_o = 1'b1;
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regbank_mp.sv
// Multi-port integer register bank: NUM_RD combinational read ports, two
// prioritised write ports (port 1 wins on conflict) and a hardwired zero
// register at ZERO_IDX. The array is zeroed by a clear sequencer after reset
// or on request; reads return 0 while the sequence runs.
// Optional feature: define REGBANK_BYPASS_EN to forward same-cycle write
// data to matching read ports while running.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          NUM_RD   = 2,
  parameter int unsigned ZERO_IDX = (2 ** ADDR_W) - 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  input  logic [1:0]               WrEn,
  input  logic [2*ADDR_W-1:0]      WrAddr,
  input  logic [2*DATA_W-1:0]      WrData,
  input  logic                     Clear,
  output logic                     Ready
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic              run;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic [ADDR_W-1:0] wr_addr [2];
  logic [DATA_W-1:0] wr_data [2];
  logic [1:0]        wr_ok;
  logic              wr0_keep;

  logic [DATA_W-1:0] mem_q [DEPTH];

  regbank_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .clear_i    (Clear),
    .ready_o    (run),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign Ready = run;

  // Unpack write ports; a write is live only while running and never to XZR.
  for (genvar gk = 0; gk < 2; gk++) begin : g_wr
    assign wr_addr[gk] = WrAddr[gk*ADDR_W +: ADDR_W];
    assign wr_data[gk] = WrData[gk*DATA_W +: DATA_W];
    assign wr_ok[gk]   = run && WrEn[gk] && (wr_addr[gk] != ZERO_A);
  end

  // Port 0 is dropped when port 1 targets the same entry in the same cycle.
  assign wr0_keep = wr_ok[0] &&
                    !(wr_ok[1] && (wr_addr[0] == wr_addr[1]) &&
                      wr_prio_sel(2'b11));

  // Array update: the clear walk has sole access in CLEAR; normal writes in RUN.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (wr0_keep) mem_q[wr_addr[0]] <= wr_data[0];
      if (wr_ok[1]) mem_q[wr_addr[1]] <= wr_data[1];
    end
  end

  // Read ports: zero during clear and for XZR, otherwise array (or bypass) data.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        hit;

    assign rd_addr = RdAddr[gi*ADDR_W +: ADDR_W];

    // Which write ports target this read address right now (used by bypass).
    always_comb begin
      hit = '0;
      for (int k = 0; k < 2; k++) begin
        hit[k] = wr_ok[k] && (wr_addr[k] == rd_addr);
      end
    end

    // Select the returned value for this read port.
    always_comb begin
      rd_data = '0;
      if (run && (rd_addr != ZERO_A)) begin
        rd_data = mem_q[rd_addr];
`ifdef REGBANK_BYPASS_EN
        if (|hit) begin
          rd_data = wr_data[wr_prio_sel(hit)];
        end
`endif
      end
    end

`ifndef REGBANK_BYPASS_EN
    // Without forwarding the hit vector has no consumer.
    logic unused_hit;
    assign unused_hit = ^hit;
`endif

    assign RdData[gi*DATA_W +: DATA_W] = rd_data;
  end

endmodule
